// File: rtl/grid_click_ctrl_pkg.sv
// Shared definitions for the 3x3 grid click path: FSM encodings, the
// "outside the grid" region code and the default screen boundaries.
package grid_click_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [3:0] REGION_NONE = 4'hF;

    localparam logic [7:0] X_B1_DEF  = 8'd53;
    localparam logic [7:0] X_B2_DEF  = 8'd107;
    localparam logic [7:0] X_MAX_DEF = 8'd161;
    localparam logic [7:0] Y_B1_DEF  = 8'd40;
    localparam logic [7:0] Y_B2_DEF  = 8'd80;
    localparam logic [7:0] Y_MAX_DEF = 8'd120;

    localparam int unsigned HOLD_CYC_DEF = 1000;

    // Button edge seen in the most recent packet, consumed one cycle later.
    typedef struct packed {
        logic rise;
        logic fall;
    } btn_evt_t;

    function automatic logic [3:0] region_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/grid_click_ctrl_region_calc.sv
// Combinational mapping of a screen x/y position onto the 3x3 grid region
// (row*3 + col, row 0 at the bottom), or REGION_NONE off-screen.
module grid_region_calc
    import grid_click_ctrl_pkg::*;
#(
    parameter logic [7:0] X_B1  = X_B1_DEF,
    parameter logic [7:0] X_B2  = X_B2_DEF,
    parameter logic [7:0] X_MAX = X_MAX_DEF,
    parameter logic [7:0] Y_B1  = Y_B1_DEF,
    parameter logic [7:0] Y_B2  = Y_B2_DEF,
    parameter logic [7:0] Y_MAX = Y_MAX_DEF
) (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [3:0] region
);

    logic [1:0] col;
    logic [1:0] row;

    always_comb begin
        col = 2'd2;
        if (x < X_B1) begin
            col = 2'd0;
        end else if (x < X_B2) begin
            col = 2'd1;
        end

        row = 2'd2;
        if (y < Y_B1) begin
            row = 2'd0;
        end else if (y < Y_B2) begin
            row = 2'd1;
        end

        region = region_index(row, col);
        if ((x > X_MAX) || (y > Y_MAX)) begin
            region = REGION_NONE;
        end
    end

endmodule

// File: rtl/grid_click_ctrl.sv
// Turns a press/release pair in one grid region into a single committed
// display code, presented downstream and followed by a hold-off period.
module grid_click_ctrl
    import grid_click_ctrl_pkg::*;
#(
    parameter logic [7:0]  X_B1     = X_B1_DEF,
    parameter logic [7:0]  X_B2     = X_B2_DEF,
    parameter logic [7:0]  X_MAX    = X_MAX_DEF,
    parameter logic [7:0]  Y_B1     = Y_B1_DEF,
    parameter logic [7:0]  Y_B2     = Y_B2_DEF,
    parameter logic [7:0]  Y_MAX    = Y_MAX_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  mouse_x,
    input  logic [7:0]  mouse_y,
    input  logic        mouse_left,
    input  logic        mouse_valid,
    output logic [15:0] dec_in,
    input  logic [15:0] dec_out,
    output logic [3:0]  region,
    output logic [15:0] sel_code,
    output logic        sel_valid,
    input  logic        sel_ready,
    output logic        busy,
    output logic [1:0]  state
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

    logic [3:0]       region_next;
    logic             prev_btn;
    btn_evt_t         evt;
    logic [3:0]       press_region;
    logic [CNT_W-1:0] hold_cnt;

    grid_region_calc #(
        .X_B1  (X_B1),
        .X_B2  (X_B2),
        .X_MAX (X_MAX),
        .Y_B1  (Y_B1),
        .Y_B2  (Y_B2),
        .Y_MAX (Y_MAX)
    ) u_region (
        .x      (mouse_x),
        .y      (mouse_y),
        .region (region_next)
    );

    // Packet capture runs in every state so the button tracker never misses
    // a level change; the FSM consumes evt one cycle later, once DEC_OUT has
    // settled on the registered coordinates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dec_in   <= '0;
            region   <= REGION_NONE;
            prev_btn <= 1'b0;
            evt      <= '0;
        end else begin
            evt <= '0;
            if (mouse_valid) begin
                dec_in   <= {mouse_x, mouse_y};
                region   <= region_next;
                prev_btn <= mouse_left;
                evt.rise <= mouse_left & ~prev_btn;
                evt.fall <= ~mouse_left & prev_btn;
            end
        end
    end

    // Handshake: sel_valid is high for the whole PRESENT state with sel_code
    // frozen; a transfer happens on any edge where sel_valid & sel_ready.
    assign sel_valid = (state == ST_PRESENT);
    assign busy      = (state == ST_PRESENT) || (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            press_region <= REGION_NONE;
            sel_code     <= '0;
            hold_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (evt.rise && (region != REGION_NONE)) begin
                        press_region <= region;
                        state        <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (evt.fall) begin
                        if (region == press_region) begin
                            sel_code <= dec_out;
                            state    <= ST_PRESENT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (sel_ready) begin
                        hold_cnt <= HOLD_LOAD;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
